mdio_master_param: RTL and testbench
====================================

# mdio_master_param

Parametrised MDIO management master: next generation of the MDIO controller, driving Clause 22 (optionally Clause 45) frames onto MDC/MDIO from a 32-bit command word. Adds a programmable MDC divider, configurable preamble, turnaround checking, a busy flag and command validation. It sits between the management host logic and the PHY-side tristate pad (MDIO_OUT/MDIO_OE/MDIO_IN).

## Interface
- CLK_DIV, default 1: MDC half-period in CLK cycles (≥1); bit period = 2·CLK_DIV cycles.
- PREAMBLE_LEN, default 32: number of '1' preamble bits before ST, range 0..32.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- MDIO_START  in  1  start request; honoured only when BUSY=0.
- T_DATA  in  32  frame {ST[31:30], OP[29:28], PHYAD[27:23], REGAD[22:18], TA[17:16], DATA[15:0]}; latched on accepted START.
- MDIO_IN  in  1  serial data from the pad.
- RD_DATA  out  16  last read data; held until the next read completes.
- DATA_RDY  out  1  one-cycle pulse at the end of every transaction (read or write).
- RD_ERR  out  1  TA check failed on the last read; held until the next accepted START.
- CMD_ERR  out  1  one-cycle pulse: START rejected as an invalid frame.
- BUSY  out  1  transaction in progress.
- MDC  out  1  management clock.
- MDIO_OE  out  1  pad output enable.
- MDIO_OUT  out  1  serial data to the pad.

## Operation
- States: IDLE, PREAMBLE, SEND, TA_RX, RECEIVE, DONE.
- IDLE: MDC=0, MDIO_OE=0, BUSY=0. A valid START loads T_DATA into the shift register and clears RD_ERR. Next state is PREAMBLE, or SEND when PREAMBLE_LEN=0.
- Valid frame: ST=01 with OP=01 (write) or OP=10 (read). Any other value pulses CMD_ERR for one cycle and the block stays in IDLE.
- PREAMBLE: MDIO_OE=1, MDIO_OUT=1 for PREAMBLE_LEN bits.
- SEND, write: all 32 bits go out MSB first. TA is forced to 10 regardless of T_DATA[17:16]. Then DONE.
- SEND, read: 14 bits (ST, OP, PHYAD, REGAD). Then TA_RX.
- TA_RX: MDIO_OE=0 for 2 bits. RD_ERR is set if MDIO_IN sampled during the second TA bit is 1. The transaction continues either way.
- RECEIVE: 16 bits are sampled MSB first into a shift register. RD_DATA updates on entry to DONE.
- DONE: lasts one cycle. DATA_RDY=1, BUSY=0, MDIO_OE=0, MDC=0. A START in DONE is accepted.
- MDIO_START while BUSY=1 is ignored, with no error.

## Timing
- Reset values: MDC=0, MDIO_OE=0, MDIO_OUT=0, RD_DATA=0, DATA_RDY=0, RD_ERR=0, CMD_ERR=0, BUSY=0. State is IDLE and the divider is cleared.
- RESET mid-transaction aborts on the next edge. No DATA_RDY is produced and RD_DATA keeps its reset value of 0.
- Start edge: START is sampled at edge 0. BUSY=1 from cycle 1.
- Bit timing: bit k starts with its low phase at cycle 1+2·CLK_DIV·k, where k counts from 0 at the first preamble bit.
- MDC rises after CLK_DIV cycles and falls after another CLK_DIV cycles.
- MDIO_OUT and MDIO_OE change only at the start of a low phase, so they are stable across every MDC rise.
- MDIO_IN is sampled on the CLK edge that drives MDC 0→1.
- Every transaction occupies N = (PREAMBLE_LEN+32)·2·CLK_DIV cycles with BUSY=1 (cycles 1..N). DATA_RDY is high in cycle N+1.
- Divider: counter of width $clog2(CLK_DIV)+1; it wraps at CLK_DIV−1 and toggles MDC.

## Configuration
- MDIO_CL45_EN defined: ST=00 is also valid.
  - OP=00 (address) and OP=01 (write) follow the write path.
  - OP=11 (read) and OP=10 (post-read-increment) follow the read path.
  - ST=01 behaviour is unchanged.
- MDIO_CL45_EN undefined: only ST=01 frames with OP=01/10 are valid; everything else raises CMD_ERR.

## Test plan
- Write, defaults: T_DATA={01,01,00001,00010,00,16'h3C33}.
  - MDIO_OUT shows 32 ones, then 0101_00001_00010_10_0011110000110011.
  - MDIO_OE=1 for 128 cycles; DATA_RDY pulses at cycle 129; RD_ERR=0.
- Read, PHY 3 reg 4: bench drives Z/0 on TA and 16'hA5C3.
  - MDIO_OE falls at bit 46.
  - RD_DATA=16'hA5C3 with DATA_RDY at cycle 129; RD_ERR=0.
- Read with MDIO_IN held 1: RD_DATA=16'hFFFF and RD_ERR=1, held until the next START.
- T_DATA OP=00, ST=01 (macro undefined): CMD_ERR pulses 1 cycle, BUSY stays 0, MDC stays 0.
  - With MDIO_CL45_EN and ST=00, OP=11: a read completes.
- RESET at bit 20 of a read: all outputs are at reset values the next cycle. An immediate write then completes correctly.
- CLK_DIV=3, PREAMBLE_LEN=0:
  - MDC period is 6 cycles and the write lasts 192 cycles.
  - A START pulsed at cycle 50 is ignored.

Source files
------------

// File: rtl/mdio_master_param.sv
// MDIO management master: shifts a 32-bit command word out on MDC/MDIO with a programmable
// divider and preamble. Define MDIO_CL45_EN to also accept Clause 45 frames (ST=00).
module mdio_master_param #(
   parameter int unsigned CLK_DIV      = 1,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MDIO_START,
   input  logic [31:0] T_DATA,
   input  logic        MDIO_IN,
   output logic [15:0] RD_DATA,
   output logic        DATA_RDY,
   output logic        RD_ERR,
   output logic        CMD_ERR,
   output logic        BUSY,
   output logic        MDC,
   output logic        MDIO_OE,
   output logic        MDIO_OUT
);

   localparam int unsigned     CntW    = $clog2(CLK_DIV) + 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
   localparam logic [5:0]      PreLast = (PREAMBLE_LEN == 0) ? 6'd0 : 6'(PREAMBLE_LEN - 1);
`ifdef MDIO_CL45_EN
   localparam bit Cl45En = 1'b1;
`else
   localparam bit Cl45En = 1'b0;
`endif

   typedef enum logic [2:0] {
      StIdle, StPreamble, StSend, StTaRx, StReceive, StDone
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            mdc_q, mdc_d;
   logic [5:0]      bit_q, bit_d;
   logic [31:0]     sh_q, sh_d;
   logic [15:0]     rx_q, rx_d;
   logic [15:0]     rd_data_q, rd_data_d;
   logic            rd_err_q, rd_err_d;
   logic            cmd_err_q, cmd_err_d;
   logic            read_q, read_d;
   logic            cmd_valid, cmd_read, active, rise, fall;

   always_comb begin
      cmd_valid = 1'b0;
      cmd_read  = 1'b0;
      if (T_DATA[31:30] == 2'b01) begin
         cmd_valid = (T_DATA[29:28] == 2'b01) || (T_DATA[29:28] == 2'b10);
         cmd_read  = (T_DATA[29:28] == 2'b10);
      end else if (Cl45En && (T_DATA[31:30] == 2'b00)) begin
         // Clause 45: OP=00/01 address/write, OP=10/11 read variants
         cmd_valid = 1'b1;
         cmd_read  = T_DATA[29];
      end
   end

   assign active = (state_q != StIdle) && (state_q != StDone);
   assign rise   = active && !mdc_q && (cnt_q == CntMax);
   assign fall   = active && mdc_q && (cnt_q == CntMax);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mdc_d     = mdc_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      rd_err_d  = rd_err_q;
      cmd_err_d = 1'b0;
      read_d    = read_q;

      if (active) begin
         if (cnt_q == CntMax) begin
            cnt_d = '0;
            mdc_d = !mdc_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end

      if (rise) begin
         if ((state_q == StTaRx) && (bit_q == 6'd1) && MDIO_IN) rd_err_d = 1'b1;
         if (state_q == StReceive) rx_d = {rx_q[14:0], MDIO_IN};
      end

      // Falling MDC marks the bit boundary: all pad and state changes happen here
      if (fall) begin
         bit_d = bit_q + 6'd1;
         case (state_q)
            StPreamble: if (bit_q == PreLast) begin
               state_d = StSend;
               bit_d   = 6'd0;
            end
            StSend: begin
               sh_d = {sh_q[30:0], 1'b0};
               if (bit_q == (read_q ? 6'd13 : 6'd31)) begin
                  state_d = read_q ? StTaRx : StDone;
                  bit_d   = 6'd0;
               end
            end
            StTaRx: if (bit_q == 6'd1) begin
               state_d = StReceive;
               bit_d   = 6'd0;
            end
            StReceive: if (bit_q == 6'd15) begin
               state_d   = StDone;
               bit_d     = 6'd0;
               rd_data_d = rx_q;
            end
            default: ;
         endcase
      end

      if (state_q == StDone) state_d = StIdle;

      if (!active && MDIO_START) begin
         if (cmd_valid) begin
            state_d  = (PREAMBLE_LEN == 0) ? StSend : StPreamble;
            cnt_d    = '0;
            mdc_d    = 1'b0;
            bit_d    = 6'd0;
            rd_err_d = 1'b0;
            read_d   = cmd_read;
            sh_d     = {T_DATA[31:18], (cmd_read ? T_DATA[17:16] : 2'b10), T_DATA[15:0]};
         end else begin
            cmd_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         mdc_q     <= 1'b0;
         bit_q     <= 6'd0;
         sh_q      <= 32'd0;
         rx_q      <= 16'd0;
         rd_data_q <= 16'd0;
         rd_err_q  <= 1'b0;
         cmd_err_q <= 1'b0;
         read_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mdc_q     <= mdc_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
         cmd_err_q <= cmd_err_d;
         read_q    <= read_d;
      end
   end

   assign MDC      = mdc_q;
   assign BUSY     = active;
   assign DATA_RDY = (state_q == StDone);
   assign RD_DATA  = rd_data_q;
   assign RD_ERR   = rd_err_q;
   assign CMD_ERR  = cmd_err_q;
   assign MDIO_OE  = (state_q == StPreamble) || (state_q == StSend);
   assign MDIO_OUT = (state_q == StPreamble) || ((state_q == StSend) && sh_q[31]);

endmodule

// File: tb/tb_mdio_master_param.sv
// Scoreboard bench for mdio_master_param: default instance plus a CLK_DIV=3, PREAMBLE_LEN=0 one.
module tb_mdio_master_param;

   typedef struct {
      int          inst;
      logic [15:0] rd;
      logic        err;
      int          n;
      int          oe;
      int          nb;
      logic [63:0] sr;
   } exp_t;

   localparam logic [31:0] W1    = 32'h5088_3C33;  // ST01 OP01 PHY1 REG2 TA00 3C33
   localparam logic [31:0] W1SER = 32'h508A_3C33;  // same with TA forced to 10
   localparam logic [31:0] R1    = 32'h6190_0000;  // ST01 OP10 PHY3 REG4

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start;
   logic [31:0] tdata [2];
   logic        phy0_in;
   logic [15:0] rd_data [2];
   logic [1:0]  rdy, rd_err, cmd_err, busy, mdc, oe, dout;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   int   busy_cnt[2], oe_cnt[2], hi_cnt[2], nb[2], rel[2], done_cnt[2];
   logic [63:0] sr[2];
   logic mdc_p[2], out_p[2], oe_p[2];
   bit   mon_en = 1'b0;
   int   phy_mode = 0;
   logic [15:0] phy_word = 16'hA5C3;

   always #5 clk = ~clk;

   mdio_master_param dut0 (
      .CLK(clk), .RESET(rst), .MDIO_START(start[0]), .T_DATA(tdata[0]), .MDIO_IN(phy0_in),
      .RD_DATA(rd_data[0]), .DATA_RDY(rdy[0]), .RD_ERR(rd_err[0]), .CMD_ERR(cmd_err[0]),
      .BUSY(busy[0]), .MDC(mdc[0]), .MDIO_OE(oe[0]), .MDIO_OUT(dout[0])
   );

   mdio_master_param #(.CLK_DIV(3), .PREAMBLE_LEN(0)) dut1 (
      .CLK(clk), .RESET(rst), .MDIO_START(start[1]), .T_DATA(tdata[1]), .MDIO_IN(1'b1),
      .RD_DATA(rd_data[1]), .DATA_RDY(rdy[1]), .RD_ERR(rd_err[1]), .CMD_ERR(cmd_err[1]),
      .BUSY(busy[1]), .MDC(mdc[1]), .MDIO_OE(oe[1]), .MDIO_OUT(dout[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor + PHY model: counts pad activity per transaction and scores it on DATA_RDY
   always @(negedge clk) begin
      exp_t e;
      int   k;
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            if (busy[i]) rel[i]++; else rel[i] = 0;
            if (busy[i]) busy_cnt[i]++;
            if (oe[i]) oe_cnt[i]++;
            if (mdc[i]) hi_cnt[i]++;
            if (mdc[i] && !mdc_p[i] && oe[i]) begin
               sr[i] = {sr[i][62:0], dout[i]};
               nb[i]++;
            end
            if ((dout[i] !== out_p[i]) || (oe[i] !== oe_p[i]))
               chk($sformatf("pad_change_in_low_phase_%0d", i), {63'd0, mdc[i]}, 64'd0);
            mdc_p[i] = mdc[i];
            out_p[i] = dout[i];
            oe_p[i]  = oe[i];
            if (rdy[i]) begin
               chk($sformatf("busy_low_in_done_%0d", i), {63'd0, busy[i]}, 64'd0);
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_data_rdy_%0d: got pulse, expected none", i);
               end else begin
                  e = exp_q.pop_front();
                  chk("scoreboard_instance", i, e.inst);
                  chk($sformatf("rd_data_%0d", i), {48'd0, rd_data[i]}, {48'd0, e.rd});
                  chk($sformatf("rd_err_%0d", i), {63'd0, rd_err[i]}, {63'd0, e.err});
                  chk($sformatf("busy_cycles_%0d", i), busy_cnt[i], e.n);
                  chk($sformatf("oe_cycles_%0d", i), oe_cnt[i], e.oe);
                  chk($sformatf("mdc_high_cycles_%0d", i), hi_cnt[i], e.n / 2);
                  chk($sformatf("driven_bits_%0d", i), nb[i], e.nb);
                  chk($sformatf("serial_out_%0d", i), sr[i], e.sr);
               end
               done_cnt[i]++;
            end
            if (!busy[i]) begin
               busy_cnt[i] = 0;
               oe_cnt[i]   = 0;
               hi_cnt[i]   = 0;
               nb[i]       = 0;
               sr[i]       = 64'd0;
            end
         end
      end
      // Bit index seen by the PHY; only TA bit 47 and data bits 48..63 matter to the DUT
      k = (rel[0] - 1) / 2;
      if (phy_mode == 1 || k <= 46) phy0_in = 1'b1;
      else if (k == 47)             phy0_in = 1'b0;
      else                          phy0_in = phy_word[63 - k];
   end

   task automatic push(input int inst, input logic [15:0] rd, input logic err, input int n,
                       input int oec, input int nbits, input logic [63:0] s);
      exp_t e;
      e.inst = inst; e.rd = rd; e.err = err; e.n = n; e.oe = oec; e.nb = nbits; e.sr = s;
      exp_q.push_back(e);
   endtask

   task automatic issue(input int i, input logic [31:0] td);
      tdata[i] = td;
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int c0 = done_cnt[i];
      int t = 0;
      while (done_cnt[i] == c0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt[i] == c0) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout_%0d: got no DATA_RDY, expected one within 1000 cycles", i);
      end
      @(negedge clk);
   endtask

   task automatic wait_rdy(input int i);
      int t = 0;
      while (!rdy[i] && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("rdy_seen_%0d", i), {63'd0, rdy[i]}, 64'd1);
   endtask

   task automatic check_reset(input int i);
      chk($sformatf("rst_mdc_%0d", i), {63'd0, mdc[i]}, 64'd0);
      chk($sformatf("rst_oe_%0d", i), {63'd0, oe[i]}, 64'd0);
      chk($sformatf("rst_out_%0d", i), {63'd0, dout[i]}, 64'd0);
      chk($sformatf("rst_rd_data_%0d", i), {48'd0, rd_data[i]}, 64'd0);
      chk($sformatf("rst_rdy_%0d", i), {63'd0, rdy[i]}, 64'd0);
      chk($sformatf("rst_rd_err_%0d", i), {63'd0, rd_err[i]}, 64'd0);
      chk($sformatf("rst_cmd_err_%0d", i), {63'd0, cmd_err[i]}, 64'd0);
      chk($sformatf("rst_busy_%0d", i), {63'd0, busy[i]}, 64'd0);
   endtask

   task automatic bad_cmd(input logic [31:0] td);
      issue(0, td);
      chk("cmd_err_pulse", {63'd0, cmd_err[0]}, 64'd1);
      chk("cmd_err_busy", {63'd0, busy[0]}, 64'd0);
      chk("cmd_err_mdc", {63'd0, mdc[0]}, 64'd0);
      @(negedge clk);
      chk("cmd_err_one_cycle", {63'd0, cmd_err[0]}, 64'd0);
      chk("cmd_err_stay_idle", {63'd0, busy[0]}, 64'd0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 2'b00;
      tdata[0] = 32'd0;
      tdata[1] = 32'd0;
      for (int i = 0; i < 2; i++) begin
         busy_cnt[i] = 0; oe_cnt[i] = 0; hi_cnt[i] = 0; nb[i] = 0; rel[i] = 0;
         done_cnt[i] = 0; sr[i] = 64'd0; mdc_p[i] = 1'b0; out_p[i] = 1'b0; oe_p[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Default write: 32 preamble ones then the frame with TA=10
      push(0, 16'h0000, 1'b0, 128, 128, 64, {32'hFFFF_FFFF, W1SER});
      issue(0, W1);
      wait_done(0);

      // Read with valid turnaround (TA bit 0 driven 1, bit 1 driven 0)
      phy_mode = 0;
      push(0, 16'hA5C3, 1'b0, 128, 92, 46, 64'h0000_3FFF_FFFF_D864);
      issue(0, R1);
      wait_done(0);

      // Read with MDIO_IN stuck high
      phy_mode = 1;
      push(0, 16'hFFFF, 1'b1, 128, 92, 46, 64'h0000_3FFF_FFFF_D864);
      issue(0, R1);
      wait_done(0);
      repeat (5) @(negedge clk);
      chk("rd_err_held", {63'd0, rd_err[0]}, 64'd1);
      chk("rd_data_held", {48'd0, rd_data[0]}, 64'h0000_0000_0000_FFFF);

      // Write clears RD_ERR on accept, then a second write is started in the DONE cycle
      phy_mode = 0;
      push(0, 16'hFFFF, 1'b0, 128, 128, 64, {32'hFFFF_FFFF, W1SER});
      issue(0, W1);
      chk("rd_err_cleared_on_start", {63'd0, rd_err[0]}, 64'd0);
      chk("busy_cycle1", {63'd0, busy[0]}, 64'd1);
      wait_rdy(0);
      push(0, 16'hFFFF, 1'b0, 128, 128, 64, {32'hFFFF_FFFF, W1SER});
      issue(0, W1);
      chk("start_in_done_accepted", {63'd0, busy[0]}, 64'd1);
      wait_done(0);

      // Invalid frames
      bad_cmd(32'h4088_0000);  // ST01 OP00
      bad_cmd(32'h7190_0000);  // ST01 OP11
`ifdef MDIO_CL45_EN
      push(0, 16'hA5C3, 1'b0, 128, 92, 46, 64'h0000_3FFF_FFFF_CC64);
      issue(0, 32'h3190_0000);  // ST00 OP11 read
      wait_done(0);
`else
      bad_cmd(32'h3190_0000);
`endif

      // Reset at bit 20 of a read, then an immediate write
      issue(0, R1);
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset(0);
      push(0, 16'h0000, 1'b0, 128, 128, 64, {32'hFFFF_FFFF, W1SER});
      issue(0, W1);
      wait_done(0);

      // CLK_DIV=3, no preamble; START during the transaction is ignored
      push(1, 16'h0000, 1'b0, 192, 192, 32, {32'h0, W1SER});
      issue(1, W1);
      repeat (49) @(negedge clk);
      issue(1, R1);
      wait_done(1);
      repeat (10) @(negedge clk);
      chk("no_pending_transactions", exp_q.size(), 0);
      chk("div3_idle_after", {63'd0, busy[1]}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish within 500000 time units");
      $fatal(1);
   end

endmodule
